// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by the joypad target and the nes_bridge initiator.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_TX       = 3'd3,
    ST_TX_ACK   = 3'd4,
    ST_RX       = 3'd5,
    ST_RX_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } i2c_state_e;

  localparam logic        I2C_RW_READ  = 1'b1;
  localparam logic        I2C_ACK      = 1'b0;
  localparam logic [6:0]  I2C_TGT_ADDR = 7'h52;
  localparam logic [7:0]  I2C_ID_BYTE  = 8'hA5;
  localparam int unsigned I2C_FILT     = 32'd3;

  function automatic logic addr_hit(input logic [7:0] addr_byte, input logic [6:0] addr);
    return (addr_byte[7:1] == addr);
  endfunction

endpackage

// File: rtl/i2c_joypad_target_if.sv
// Pin-level I2C bundle between an initiator (drives SCL/SDA levels) and the target.
interface i2c_joypad_target_if;
  logic scl_in;
  logic sda_in;
  logic sda_out;

  modport master (output scl_in, output sda_in, input sda_out);
  modport slave  (input scl_in, input sda_in, output sda_out);
endinterface

// File: rtl/i2c_line_filter.sv
// Synchronises and glitch-filters SCL/SDA, then emits registered edge/START/STOP pulses.
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int unsigned FILT = I2C_FILT
) (
  input  logic clk_half,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_level,
  output logic start,
  output logic stop
);

  logic [1:0]      meta_r;
  logic [1:0]      sync_r;
  logic [FILT-2:0] scl_hist_r;
  logic [FILT-2:0] sda_hist_r;
  logic            scl_lvl_r;
  logic            sda_lvl_r;
  logic            scl_rise_r;
  logic            scl_fall_r;
  logic            start_r;
  logic            stop_r;
  logic [FILT-1:0] scl_win_s;
  logic [FILT-1:0] sda_win_s;
  logic            scl_hi_s;
  logic            scl_lo_s;
  logic            sda_hi_s;
  logic            sda_lo_s;

  // The newest synchronised sample plus FILT-1 older ones form the agreement window.
  assign scl_win_s = {scl_hist_r, sync_r[1]};
  assign sda_win_s = {sda_hist_r, sync_r[0]};
  assign scl_hi_s  = &scl_win_s;
  assign scl_lo_s  = ~|scl_win_s;
  assign sda_hi_s  = &sda_win_s;
  assign sda_lo_s  = ~|sda_win_s;

  // Synchroniser, filter history, accepted levels and event pulses.
  always_ff @(posedge clk_half or negedge rst_n) begin
    if (!rst_n) begin
      meta_r     <= 2'b11;
      sync_r     <= 2'b11;
      scl_hist_r <= '1;
      sda_hist_r <= '1;
      scl_lvl_r  <= 1'b1;
      sda_lvl_r  <= 1'b1;
      scl_rise_r <= 1'b0;
      scl_fall_r <= 1'b0;
      start_r    <= 1'b0;
      stop_r     <= 1'b0;
    end else begin
      meta_r     <= {scl, sda};
      sync_r     <= meta_r;
      scl_hist_r <= scl_win_s[FILT-2:0];
      sda_hist_r <= sda_win_s[FILT-2:0];
      scl_lvl_r  <= scl_hi_s ? 1'b1 : (scl_lo_s ? 1'b0 : scl_lvl_r);
      sda_lvl_r  <= sda_hi_s ? 1'b1 : (sda_lo_s ? 1'b0 : sda_lvl_r);
      scl_rise_r <= scl_hi_s & ~scl_lvl_r;
      scl_fall_r <= scl_lo_s & scl_lvl_r;
      start_r    <= sda_lo_s & sda_lvl_r & scl_lvl_r;
      stop_r     <= sda_hi_s & ~sda_lvl_r & scl_lvl_r;
    end
  end

  assign scl_rise  = scl_rise_r;
  assign scl_fall  = scl_fall_r;
  assign sda_level = sda_lvl_r;
  assign start     = start_r;
  assign stop      = stop_r;

endmodule

// File: rtl/i2c_joypad_target.sv
// I2C target: serves a joypad snapshot and an ID byte on reads, captures one command byte on writes.
module i2c_joypad_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  ADDR    = I2C_TGT_ADDR,
  parameter logic [7:0]  ID_BYTE = I2C_ID_BYTE,
  parameter int unsigned FILT    = I2C_FILT
) (
  input  logic                clk_half,
  input  logic                rst_n,
  i2c_joypad_target_if.slave  bus,
  input  logic [7:0]          joypad,
  output logic [7:0]          cmd,
  output logic                cmd_valid,
  output logic                rd_done,
  output logic                busy
);

  logic rise_s, fall_s, sda_lvl_s, start_s, stop_s;

  i2c_line_filter #(.FILT(FILT)) u_filter (
    .clk_half  (clk_half),
    .rst_n     (rst_n),
    .scl       (bus.scl_in),
    .sda       (bus.sda_in),
    .scl_rise  (rise_s),
    .scl_fall  (fall_s),
    .sda_level (sda_lvl_s),
    .start     (start_s),
    .stop      (stop_s)
  );

  i2c_state_e state_r, state_nxt;
  logic [3:0] bit_cnt_r, bit_cnt_nxt;
  logic [7:0] shift_r, shift_nxt;
  logic [7:0] snap_r, snap_nxt;
  logic [7:0] cmd_r, cmd_nxt;
  logic       sda_r, sda_nxt;
  logic       busy_r, busy_nxt;
  logic       idx_r, idx_nxt;
  logic       rw_r, rw_nxt;
  logic       first_r, first_nxt;
  logic       ack_ph_r, ack_ph_nxt;
  logic       cmd_valid_r, cmd_valid_nxt;
  logic       rd_done_r, rd_done_nxt;
  logic [7:0] shift_in_s;
  logic [7:0] cur_byte_s;

  assign shift_in_s = {shift_r[6:0], sda_lvl_s};
  assign cur_byte_s = idx_r ? ID_BYTE : snap_r;

  // State and datapath registers; async reset releases SDA immediately.
  always_ff @(posedge clk_half or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 4'd0;
      shift_r     <= 8'h00;
      snap_r      <= 8'h00;
      cmd_r       <= 8'h00;
      sda_r       <= 1'b1;
      busy_r      <= 1'b0;
      idx_r       <= 1'b0;
      rw_r        <= 1'b0;
      first_r     <= 1'b0;
      ack_ph_r    <= 1'b0;
      cmd_valid_r <= 1'b0;
      rd_done_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      bit_cnt_r   <= bit_cnt_nxt;
      shift_r     <= shift_nxt;
      snap_r      <= snap_nxt;
      cmd_r       <= cmd_nxt;
      sda_r       <= sda_nxt;
      busy_r      <= busy_nxt;
      idx_r       <= idx_nxt;
      rw_r        <= rw_nxt;
      first_r     <= first_nxt;
      ack_ph_r    <= ack_ph_nxt;
      cmd_valid_r <= cmd_valid_nxt;
      rd_done_r   <= rd_done_nxt;
    end
  end

  // Next-state and output decode; START/STOP override whatever byte is in flight.
  always_comb begin
    state_nxt     = state_r;
    bit_cnt_nxt   = bit_cnt_r;
    shift_nxt     = shift_r;
    snap_nxt      = snap_r;
    cmd_nxt       = cmd_r;
    sda_nxt       = sda_r;
    busy_nxt      = busy_r;
    idx_nxt       = idx_r;
    rw_nxt        = rw_r;
    first_nxt     = first_r;
    ack_ph_nxt    = ack_ph_r;
    cmd_valid_nxt = 1'b0;
    rd_done_nxt   = 1'b0;
    if (stop_s) begin
      state_nxt = ST_IDLE;
      sda_nxt   = 1'b1;
      busy_nxt  = 1'b0;
    end else if (start_s) begin
      state_nxt   = ST_ADDR;
      bit_cnt_nxt = 4'd0;
      sda_nxt     = 1'b1;
    end else begin
      case (state_r)
        ST_ADDR: begin
          if (rise_s) begin
            shift_nxt   = shift_in_s;
            bit_cnt_nxt = bit_cnt_r + 4'd1;
            if (bit_cnt_r == 4'd7) begin
              if (addr_hit(shift_in_s, ADDR)) begin
                state_nxt  = ST_ADDR_ACK;
                busy_nxt   = 1'b1;
                snap_nxt   = joypad;
                idx_nxt    = 1'b0;
                rw_nxt     = shift_in_s[0];
                ack_ph_nxt = 1'b0;
              end else begin
                state_nxt = ST_IGNORE;
              end
            end else begin
              state_nxt = ST_ADDR;
            end
          end else begin
            state_nxt = ST_ADDR;
          end
        end
        // ack_ph_r splits the ACK slot: first fall pulls low, second fall ends the slot.
        ST_ADDR_ACK: begin
          if (fall_s) begin
            if (!ack_ph_r) begin
              sda_nxt    = I2C_ACK;
              ack_ph_nxt = 1'b1;
            end else if (rw_r == I2C_RW_READ) begin
              state_nxt   = ST_TX;
              shift_nxt   = cur_byte_s;
              sda_nxt     = cur_byte_s[7];
              bit_cnt_nxt = 4'd1;
            end else begin
              state_nxt   = ST_RX;
              sda_nxt     = 1'b1;
              bit_cnt_nxt = 4'd0;
              first_nxt   = 1'b1;
            end
          end else begin
            ack_ph_nxt = ack_ph_r;
          end
        end
        ST_TX: begin
          if (fall_s) begin
            if (bit_cnt_r == 4'd0) begin
              shift_nxt   = cur_byte_s;
              sda_nxt     = cur_byte_s[7];
              bit_cnt_nxt = 4'd1;
            end else if (bit_cnt_r == 4'd8) begin
              sda_nxt   = 1'b1;
              state_nxt = ST_TX_ACK;
            end else begin
              shift_nxt   = {shift_r[6:0], 1'b0};
              sda_nxt     = shift_r[6];
              bit_cnt_nxt = bit_cnt_r + 4'd1;
            end
          end else begin
            sda_nxt = sda_r;
          end
        end
        ST_TX_ACK: begin
          if (rise_s) begin
            if (sda_lvl_s == I2C_ACK) begin
              state_nxt   = ST_TX;
              bit_cnt_nxt = 4'd0;
              idx_nxt     = ~idx_r;
              if (idx_r) begin
                snap_nxt = joypad;
              end else begin
                snap_nxt = snap_r;
              end
            end else begin
              rd_done_nxt = 1'b1;
              state_nxt   = ST_IGNORE;
            end
          end else begin
            state_nxt = ST_TX_ACK;
          end
        end
        ST_RX: begin
          if (rise_s) begin
            shift_nxt   = shift_in_s;
            bit_cnt_nxt = bit_cnt_r + 4'd1;
            if (bit_cnt_r == 4'd7) begin
              state_nxt  = ST_RX_ACK;
              ack_ph_nxt = 1'b0;
              if (first_r) begin
                cmd_nxt       = shift_in_s;
                cmd_valid_nxt = 1'b1;
                first_nxt     = 1'b0;
              end else begin
                cmd_nxt = cmd_r;
              end
            end else begin
              state_nxt = ST_RX;
            end
          end else begin
            state_nxt = ST_RX;
          end
        end
        ST_RX_ACK: begin
          if (fall_s) begin
            if (!ack_ph_r) begin
              sda_nxt    = I2C_ACK;
              ack_ph_nxt = 1'b1;
            end else begin
              sda_nxt     = 1'b1;
              state_nxt   = ST_RX;
              bit_cnt_nxt = 4'd0;
            end
          end else begin
            ack_ph_nxt = ack_ph_r;
          end
        end
        default: begin
          state_nxt = state_r;
        end
      endcase
    end
  end

  assign bus.sda_out = sda_r;
  assign cmd         = cmd_r;
  assign cmd_valid   = cmd_valid_r;
  assign rd_done     = rd_done_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_i2c_joypad_target.sv
// Directed bench: a bit-banged initiator drives the target; a transaction-level model supplies expectations.
module tb_i2c_joypad_target;
  import i2c_pkg::*;

  localparam int H = 10;  // quarter SCL period in clk_half cycles

  logic       clk_half = 1'b0;
  logic       rst_n    = 1'b0;
  logic       scl      = 1'b1;
  logic       m_sda    = 1'b1;
  logic [7:0] joypad   = 8'h00;
  logic [7:0] cmd;
  logic       cmd_valid, rd_done, busy;

  i2c_joypad_target_if bus ();
  assign bus.scl_in = scl;
  assign bus.sda_in = m_sda & bus.sda_out;

  i2c_joypad_target dut (
    .clk_half  (clk_half),
    .rst_n     (rst_n),
    .bus       (bus),
    .joypad    (joypad),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .rd_done   (rd_done),
    .busy      (busy)
  );

  always #10 clk_half = ~clk_half;

  int n_checks = 0;
  int n_pass   = 0;
  logic       chk_en   = 1'b0;
  logic       exp_sda  = 1'b1;
  logic       exp_busy = 1'b0;
  logic [7:0] exp_cmd  = 8'h00;
  int cv_seen = 0, rd_seen = 0, exp_cv = 0, exp_rd = 0;
  logic       addressed = 1'b0;
  logic       wr_first  = 1'b0;
  logic [7:0] rd_snap   = 8'h00;
  int         rd_idx    = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  // Continuous compare of the DUT against the model inside each settled SCL-high window.
  always @(negedge clk_half) begin
    if (chk_en) begin
      check8("sda_out", {7'd0, bus.sda_out}, {7'd0, exp_sda});
      check8("busy", {7'd0, busy}, {7'd0, exp_busy});
      check8("cmd", cmd, exp_cmd);
    end
  end

  // Count high cycles of the pulse outputs; one-cycle pulses make this the pulse count.
  always @(posedge clk_half) begin
    if (cmd_valid === 1'b1) cv_seen++;
    if (rd_done === 1'b1) rd_seen++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_half);
    #2;
  endtask

  task automatic clock_bit(input logic drv, input logic dut_bit, output logic seen);
    scl = 1'b0; tick(H);
    m_sda = drv; exp_sda = dut_bit; tick(H);
    scl = 1'b1; tick(H);
    chk_en = 1'b1; tick(H);
    seen = bus.sda_in; chk_en = 1'b0;
  endtask

  task automatic start_cond();
    scl = 1'b0; tick(H);
    m_sda = 1'b1; exp_sda = 1'b1; tick(H);
    scl = 1'b1; tick(2 * H);
    m_sda = 1'b0; tick(H);
    chk_en = 1'b1; tick(H); chk_en = 1'b0;
  endtask

  task automatic stop_cond();
    scl = 1'b0; tick(H);
    m_sda = 1'b0; tick(H);
    scl = 1'b1; tick(2 * H);
    m_sda = 1'b1; exp_busy = 1'b0; exp_sda = 1'b1; addressed = 1'b0; tick(H);
    chk_en = 1'b1; tick(H); chk_en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic is_addr);
    logic seen, ack_exp;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) begin
        if (is_addr) begin
          addressed = (b[7:1] == 7'h52);
          if (addressed) begin
            exp_busy = 1'b1; rd_snap = joypad; rd_idx = 0; wr_first = 1'b1;
          end
        end else if (wr_first) begin
          exp_cmd = b; exp_cv++; wr_first = 1'b0;
        end
      end
      clock_bit(b[i], 1'b1, seen);
    end
    ack_exp = addressed ? 1'b0 : 1'b1;
    clock_bit(1'b1, ack_exp, seen);
    check8(is_addr ? "addr_ack" : "data_ack", {7'd0, seen}, {7'd0, ack_exp});
  endtask

  task automatic recv_byte(input logic m_ack, output logic [7:0] got);
    logic [7:0] want;
    logic seen;
    got  = 8'h00;
    want = rd_idx[0] ? 8'hA5 : rd_snap;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, want[i], seen);
      got[i] = seen;
    end
    clock_bit(m_ack ? 1'b0 : 1'b1, 1'b1, seen);
    if (m_ack) begin
      rd_idx++;
      if (!rd_idx[0]) rd_snap = joypad;
    end else begin
      exp_rd++;
    end
    check8("rd_byte", got, want);
  endtask

  initial begin
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] pat;
    logic seen;
    int cv0, rd0;

    tick(5);
    check8("rst_sda", {7'd0, bus.sda_out}, 8'd1);
    check8("rst_busy", {7'd0, busy}, 8'd0);
    check8("rst_cmd", cmd, 8'h00);
    check8("rst_pulses", {6'd0, cmd_valid, rd_done}, 8'd0);
    rst_n = 1'b1; tick(10);

    // Read two bytes: snapshot then ID, NACK on the second.
    joypad = 8'h81; rd0 = rd_seen;
    start_cond(); send_byte(8'hA5, 1'b1);
    recv_byte(1'b1, b0); recv_byte(1'b0, b1); stop_cond();
    check8("read_b0", b0, 8'h81);
    check8("read_b1", b1, 8'hA5);
    check8("read_rd_done", 8'(rd_seen - rd0), 8'd1);

    // Foreign address is ignored, then a START at our address is served.
    cv0 = cv_seen; rd0 = rd_seen;
    start_cond(); send_byte(8'hA7, 1'b1);
    check8("foreign_cv", 8'(cv_seen - cv0), 8'd0);
    check8("foreign_rd", 8'(rd_seen - rd0), 8'd0);
    start_cond(); send_byte(8'hA5, 1'b1); recv_byte(1'b0, b0); stop_cond();
    check8("after_foreign", b0, 8'h81);

    // Write two bytes: only the first becomes the command.
    cv0 = cv_seen;
    start_cond(); send_byte(8'hA4, 1'b1); send_byte(8'h3C, 1'b0); send_byte(8'h99, 1'b0); stop_cond();
    check8("write_cmd", cmd, 8'h3C);
    check8("write_cv", 8'(cv_seen - cv0), 8'd1);

    // Write then repeated START read, joypad changed in between.
    start_cond(); send_byte(8'hA4, 1'b1); send_byte(8'h11, 1'b0);
    joypad = 8'h40;
    start_cond(); send_byte(8'hA5, 1'b1); recv_byte(1'b0, b0); stop_cond();
    check8("rs_cmd", cmd, 8'h11);
    check8("rs_read", b0, 8'h40);

    // Four-byte read with re-latch at the wrap.
    joypad = 8'h12;
    start_cond(); send_byte(8'hA5, 1'b1);
    recv_byte(1'b1, b0); joypad = 8'h34;
    recv_byte(1'b1, b1); recv_byte(1'b1, b2); recv_byte(1'b0, b3); stop_cond();
    check8("seq_b0", b0, 8'h12);
    check8("seq_b1", b1, 8'hA5);
    check8("seq_b2", b2, 8'h34);
    check8("seq_b3", b3, 8'hA5);

    // STOP three bits into a TX byte.
    joypad = 8'hF0; rd0 = rd_seen;
    start_cond(); send_byte(8'hA5, 1'b1);
    pat = rd_snap;
    for (int i = 7; i >= 5; i--) clock_bit(1'b1, pat[i], seen);
    stop_cond();
    check8("abort_rd", 8'(rd_seen - rd0), 8'd0);

    // Reset while the target holds the address ACK low.
    pat = 8'hA4;
    start_cond();
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) exp_busy = 1'b1;
      clock_bit(pat[i], 1'b1, seen);
    end
    scl = 1'b0; tick(H); m_sda = 1'b1; tick(H); scl = 1'b1; tick(H);
    check8("ack_before_rst", {7'd0, bus.sda_out}, 8'd0);
    #3 rst_n = 1'b0;
    #1;
    check8("rst_async_sda", {7'd0, bus.sda_out}, 8'd1);
    check8("rst_async_busy", {7'd0, busy}, 8'd0);
    check8("rst_async_cmd", cmd, 8'h00);
    exp_busy = 1'b0; exp_cmd = 8'h00; addressed = 1'b0; wr_first = 1'b0;
    tick(3); rst_n = 1'b1; tick(5);
    cv0 = cv_seen;
    for (int i = 7; i >= 0; i--) clock_bit(pat[i], 1'b1, seen);
    clock_bit(1'b1, 1'b1, seen);
    check8("post_rst_nostart", {7'd0, seen}, 8'd1);
    stop_cond();
    start_cond(); send_byte(8'hA4, 1'b1); send_byte(8'h77, 1'b0); stop_cond();
    check8("post_rst_cmd", cmd, 8'h77);
    check8("post_rst_cv", 8'(cv_seen - cv0), 8'd1);

    check8("total_cv", 8'(cv_seen), 8'(exp_cv));
    check8("total_rd", 8'(rd_seen), 8'(exp_rd));
    tick(10);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
